// File: rtl/cpu_rf_pkg.sv
// -----------------------------------------------------------------------------
// cpu_rf_pkg
// Shared constants and types for the CPU register file.
//   RF_DATA_W / RF_ADDR_W : default register width and address width
//   REG_ZERO              : index of the hardwired-zero register
//   REG_SP                : index of the stack pointer register
//   SP_RESET              : reset value loaded into the stack pointer
//   rf_addr_t / rf_data_t : default-width address and data types
// -----------------------------------------------------------------------------
package cpu_rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;

    localparam logic [31:0] SP_RESET = 32'h0000_07fc;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage : cpu_rf_pkg

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// One combinational read port of the register file.
//   addr_i              : source register index
//   stored_i            : value currently held in the addressed register
//   pend_i              : scoreboard bit of the addressed register
//   wr0_* / wr1_*       : the two write-back ports, used for forwarding
//   data_o              : read data (zero for r0, else forwarded or stored)
//   busy_o              : register is reserved and no write-back covers it now
// -----------------------------------------------------------------------------
module regfile_read_port
    import cpu_rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] stored_i,
    input  logic              pend_i,
    input  logic              wr0_en_i,
    input  logic [ADDR_W-1:0] wr0_addr_i,
    input  logic [DATA_W-1:0] wr0_data_i,
    input  logic              wr1_en_i,
    input  logic [ADDR_W-1:0] wr1_addr_i,
    input  logic [DATA_W-1:0] wr1_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o
);

    logic is_zero_s;
    logic hit0_s;
    logic hit1_s;

    // Address match against r0 and against each write-back port.
    always_comb begin
        is_zero_s = (addr_i == ADDR_W'(REG_ZERO));
        hit0_s    = wr0_en_i && (wr0_addr_i == addr_i);
        hit1_s    = wr1_en_i && (wr1_addr_i == addr_i);
    end

    // Read mux: r0 first, then the load path (it wins collisions), then ALU path.
    always_comb begin
        data_o = stored_i;
        if (is_zero_s) begin
            data_o = '0;
        end else if (hit1_s) begin
            data_o = wr1_data_i;
        end else if (hit0_s) begin
            data_o = wr0_data_i;
        end else begin
            data_o = stored_i;
        end
    end

    // A write-back landing this cycle satisfies the reservation, so no stall.
    always_comb begin
        busy_o = 1'b0;
        if (!is_zero_s && pend_i && !hit0_s && !hit1_s) begin
            busy_o = 1'b1;
        end else begin
            busy_o = 1'b0;
        end
    end

endmodule : regfile_read_port

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-port register file with write forwarding and a pending scoreboard.
//   clk, reset_n  : rising-edge clock, asynchronous active-low reset
//   rd_addr       : NUM_RD packed read addresses
//   rd_data       : NUM_RD packed read data (combinational)
//   rd_busy       : per read port, source register still awaiting write-back
//   wr0_*         : write-back port 0 (ALU path)
//   wr1_*         : write-back port 1 (load path, wins address collisions)
//   sb_set_*      : reserve a destination register at issue
//   pending       : registered scoreboard vector, bit 0 always 0
// -----------------------------------------------------------------------------
module regfile_mp
    import cpu_rf_pkg::*;
#(
    parameter int                DATA_W = RF_DATA_W,
    parameter int                ADDR_W = RF_ADDR_W,
    parameter int                NUM_RD = 2,
    parameter int                SP_IDX = REG_SP,
    parameter logic [DATA_W-1:0] SP_RST = DATA_W'(SP_RESET)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     sb_set_en,
    input  logic [ADDR_W-1:0]        sb_set_addr,
    output logic [(1<<ADDR_W)-1:0]   pending
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DATA_W-1:0] rf_d [DEPTH];
    logic [DEPTH-1:0]  pending_q;
    logic [DEPTH-1:0]  pending_d;

    // Per-index reset value: only the stack pointer (if enabled) is non-zero.
    function automatic logic [DATA_W-1:0] reset_val(input int idx);
        logic [DATA_W-1:0] val;
        if ((SP_IDX != REG_ZERO) && (idx == SP_IDX)) begin
            val = SP_RST;
        end else begin
            val = '0;
        end
        return val;
    endfunction

    // Next-state storage and scoreboard; r0 is forced to zero and never pending.
    always_comb begin
        rf_d      = rf_q;
        pending_d = pending_q;
        rf_d[0]      = '0;
        pending_d[0] = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            if (wr1_en && (wr1_addr == ADDR_W'(i))) begin
                rf_d[i] = wr1_data;
            end else if (wr0_en && (wr0_addr == ADDR_W'(i))) begin
                rf_d[i] = wr0_data;
            end else begin
                rf_d[i] = rf_q[i];
            end
            // A new reservation outlives an older instruction's write-back.
            if (sb_set_en && (sb_set_addr == ADDR_W'(i))) begin
                pending_d[i] = 1'b1;
            end else if ((wr0_en && (wr0_addr == ADDR_W'(i))) ||
                         (wr1_en && (wr1_addr == ADDR_W'(i)))) begin
                pending_d[i] = 1'b0;
            end else begin
                pending_d[i] = pending_q[i];
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= reset_val(i);
            end
            pending_q <= '0;
        end else begin
            rf_q      <= rf_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        assign addr_s = rd_addr[k*ADDR_W +: ADDR_W];

        regfile_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd_port (
            .addr_i     (addr_s),
            .stored_i   (rf_q[addr_s]),
            .pend_i     (pending_q[addr_s]),
            .wr0_en_i   (wr0_en),
            .wr0_addr_i (wr0_addr),
            .wr0_data_i (wr0_data),
            .wr1_en_i   (wr1_en),
            .wr1_addr_i (wr1_addr),
            .wr1_data_i (wr1_data),
            .data_o     (rd_data[k*DATA_W +: DATA_W]),
            .busy_o     (rd_busy[k])
        );
    end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Self-checking bench for regfile_mp: a default-parameter instance checked
// against an array/bitmask reference model, plus a small NUM_RD=4, ADDR_W=3,
// SP_IDX=0 instance checked with directed constants.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    // Default-parameter instance
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr0_en, wr1_en, sb_set_en;
    logic [4:0]  wr0_addr, wr1_addr, sb_set_addr;
    logic [31:0] wr0_data, wr1_data;
    logic [31:0] pending;

    regfile_mp dut (
        .clk(clk), .reset_n(reset_n),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .pending(pending)
    );

    // Small instance: four read ports, eight registers, no stack pointer
    logic [11:0]  b_rd_addr;
    logic [127:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic         b_wr0_en, b_wr1_en, b_sb_set_en;
    logic [2:0]   b_wr0_addr, b_wr1_addr, b_sb_set_addr;
    logic [31:0]  b_wr0_data, b_wr1_data;
    logic [7:0]   b_pending;

    regfile_mp #(.DATA_W(32), .ADDR_W(3), .NUM_RD(4), .SP_IDX(0)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr0_en(b_wr0_en), .wr0_addr(b_wr0_addr), .wr0_data(b_wr0_data),
        .wr1_en(b_wr1_en), .wr1_addr(b_wr1_addr), .wr1_data(b_wr1_data),
        .sb_set_en(b_sb_set_en), .sb_set_addr(b_sb_set_addr),
        .pending(b_pending)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: plain array of register contents and a pending mask
    logic [31:0] m_rf [32];
    logic [31:0] m_pend;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m_rf[29] = 32'h0000_07fc;
        m_pend   = 32'h0;
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wr1_en && wr1_addr == a) return wr1_data;
        if (wr0_en && wr0_addr == a) return wr0_data;
        return m_rf[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (wr1_en && wr1_addr == a) return 1'b0;
        if (wr0_en && wr0_addr == a) return 1'b0;
        return m_pend[a];
    endfunction

    // Commit semantics: writes (wr1 last so it wins), then reservations win.
    task automatic model_edge();
        if (wr0_en && wr0_addr != 5'd0) begin
            m_rf[wr0_addr] = wr0_data;
            m_pend[wr0_addr] = 1'b0;
        end
        if (wr1_en && wr1_addr != 5'd0) begin
            m_rf[wr1_addr] = wr1_data;
            m_pend[wr1_addr] = 1'b0;
        end
        if (sb_set_en && sb_set_addr != 5'd0) m_pend[sb_set_addr] = 1'b1;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en = 1'b0; wr0_addr = 5'd0; wr0_data = 32'h0;
        wr1_en = 1'b0; wr1_addr = 5'd0; wr1_data = 32'h0;
        sb_set_en = 1'b0; sb_set_addr = 5'd0;
    endtask

    task automatic check_ports(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_data%0d", tag, k), 64'(rd_data[k*32 +: 32]),
                64'(exp_data(rd_addr[k*5 +: 5])));
            chk($sformatf("%s_busy%0d", tag, k), 64'(rd_busy[k]),
                64'(exp_busy(rd_addr[k*5 +: 5])));
        end
    endtask

    initial begin
        idle();
        rd_addr = {5'd5, 5'd29};
        b_wr0_en = 1'b0; b_wr0_addr = 3'd0; b_wr0_data = 32'h0;
        b_wr1_en = 1'b0; b_wr1_addr = 3'd0; b_wr1_data = 32'h0;
        b_sb_set_en = 1'b0; b_sb_set_addr = 3'd0;
        b_rd_addr = {3'd7, 3'd7, 3'd7, 3'd7};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;

        // Reset state
        chk("rst_sp",   64'(rd_data[31:0]),  64'h0000_07fc);
        chk("rst_r5",   64'(rd_data[63:32]), 64'h0);
        chk("rst_pend", 64'(pending),        64'h0);
        chk("rst_b_pend", 64'(b_pending),    64'h0);
        chk("rst_b_r7", 64'(b_rd_data[127:96]), 64'h0);

        // Dirty state, then an async reset pulse in mid-cycle
        wr0_en = 1'b1; wr0_addr = 5'd29; wr0_data = 32'h1234_5678;
        wr1_en = 1'b1; wr1_addr = 5'd5;  wr1_data = 32'h0000_0055;
        sb_set_en = 1'b1; sb_set_addr = 5'd9;
        tick();
        idle();
        chk("pre_rst_pend", 64'(pending), 64'(m_pend));
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_sp",   64'(rd_data[31:0]),  64'h0000_07fc);
        chk("async_r5",   64'(rd_data[63:32]), 64'h0);
        chk("async_pend", 64'(pending),        64'h0);
        // Write presented during reset is taken on the first edge after release
        wr0_en = 1'b1; wr0_addr = 5'd6; wr0_data = 32'h0000_a5a5;
        #1 reset_n = 1'b1;
        tick();
        idle();
        rd_addr = {5'd0, 5'd6};
        #1;
        chk("post_rst_wr", 64'(rd_data[31:0]), 64'h0000_a5a5);

        // Zero register
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hdead_beef;
        sb_set_en = 1'b1; sb_set_addr = 5'd0;
        rd_addr = {5'd0, 5'd0};
        #1;
        chk("zero_fwd0", 64'(rd_data[31:0]),  64'h0);
        chk("zero_fwd1", 64'(rd_data[63:32]), 64'h0);
        tick();
        idle();
        #1;
        chk("zero_rd", 64'(rd_data[31:0]), 64'h0);
        chk("zero_pend", 64'(pending[0]), 64'h0);

        // Write collision and forwarding
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h1111_1111;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h2222_2222;
        rd_addr = {5'd0, 5'd7};
        #1;
        chk("coll_fwd", 64'(rd_data[31:0]), 64'h2222_2222);
        tick();
        idle();
        #1;
        chk("coll_store", 64'(rd_data[31:0]), 64'h2222_2222);

        // Load-use stall; same-cycle reservation does not busy the read
        sb_set_en = 1'b1; sb_set_addr = 5'd3;
        rd_addr = {5'd0, 5'd3};
        #1;
        chk("set_same_cyc_busy", 64'(rd_busy[0]), 64'h0);
        tick();
        idle();
        #1;
        chk("lu_busy", 64'(rd_busy[0]), 64'h1);
        wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h0000_abcd;
        #1;
        chk("lu_wb_busy", 64'(rd_busy[0]), 64'h0);
        chk("lu_wb_data", 64'(rd_data[31:0]), 64'h0000_abcd);
        tick();
        idle();
        chk("lu_pend3", 64'(pending[3]), 64'h0);

        // Set/clear race
        sb_set_en = 1'b1; sb_set_addr = 5'd4;
        tick();
        chk("race_pre", 64'(pending[4]), 64'h1);
        wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h5;
        tick();
        idle();
        chk("race_pend4", 64'(pending[4]), 64'h1);
        rd_addr = {5'd0, 5'd4};
        #1;
        chk("race_data", 64'(rd_data[31:0]), 64'h5);
        chk("race_busy", 64'(rd_busy[0]), 64'h1);
        chk("race_model", 64'(pending), 64'(m_pend));

        // Randomised traffic, addresses biased low to provoke collisions
        for (int n = 0; n < 400; n++) begin
            wr0_en      = 1'($urandom_range(0, 1));
            wr1_en      = 1'($urandom_range(0, 1));
            sb_set_en   = 1'($urandom_range(0, 1));
            wr0_addr    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wr1_addr    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            sb_set_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wr0_data    = $urandom;
            wr1_data    = $urandom;
            rd_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            if ($urandom_range(0, 5) == 0) rd_addr[4:0] = 5'($urandom);
            #1;
            check_ports("rnd");
            tick();
            chk("rnd_pend", 64'(pending), 64'(m_pend));
        end
        idle();

        // Small instance: four independent reads of distinct values
        b_wr0_en = 1'b1; b_wr0_addr = 3'd1; b_wr0_data = 32'h0000_00a1;
        b_wr1_en = 1'b1; b_wr1_addr = 3'd2; b_wr1_data = 32'h0000_00b2;
        tick();
        b_wr0_addr = 3'd3; b_wr0_data = 32'h0000_00c3;
        b_wr1_addr = 3'd4; b_wr1_data = 32'h0000_00d4;
        tick();
        b_wr0_en = 1'b0; b_wr1_en = 1'b0;
        b_rd_addr = {3'd1, 3'd2, 3'd3, 3'd4};
        #1;
        chk("b_rd0", 64'(b_rd_data[31:0]),   64'h0000_00d4);
        chk("b_rd1", 64'(b_rd_data[63:32]),  64'h0000_00c3);
        chk("b_rd2", 64'(b_rd_data[95:64]),  64'h0000_00b2);
        chk("b_rd3", 64'(b_rd_data[127:96]), 64'h0000_00a1);
        b_sb_set_en = 1'b1; b_sb_set_addr = 3'd5;
        tick();
        b_sb_set_en = 1'b0;
        b_rd_addr = {3'd7, 3'd5, 3'd0, 3'd5};
        #1;
        chk("b_pend", 64'(b_pending), 64'h20);
        chk("b_busy", 64'(b_rd_busy), 64'h5);
        chk("b_r7", 64'(b_rd_data[127:96]), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined CPU core.
- Provides NUM_RD combinational read ports and two write-back ports (WB0 = ALU path, WB1 = load path).
- Adds per-register pending (scoreboard) bits so decode can detect load-use and multi-cycle hazards.
- Keeps hardwired-zero register 0, same-cycle write forwarding, and a stack-pointer reset value.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers, index 0 hardwired to zero.
- NUM_RD, 2, number of read ports (1..4).
- SP_IDX, 29, register loaded with SP_RST on reset; 0 disables.
- SP_RST, 32'h000007fc, reset value of register SP_IDX.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  port k's source register is pending and not being written this cycle.
- wr0_en  in  1  write-back port 0 enable.
- wr0_addr  in  ADDR_W  write-back port 0 address.
- wr0_data  in  DATA_W  write-back port 0 data.
- wr1_en  in  1  write-back port 1 enable.
- wr1_addr  in  ADDR_W  write-back port 1 address.
- wr1_data  in  DATA_W  write-back port 1 data.
- sb_set_en  in  1  issue reserves a destination register.
- sb_set_addr  in  ADDR_W  register to mark pending.
- pending  out  DEPTH  registered scoreboard vector; bit 0 is always 0.

Behaviour:
- Reset (reset_n low, async):
  - All registers clear to 0, except SP_IDX, which loads SP_RST.
  - All pending bits clear to 0.
  - Reset mid-operation discards in-flight writes and reservations; the first write is accepted on the first rising edge after reset_n rises.
- Storage: registers 1..DEPTH-1 are flops. Register 0 is constant 0, is never written and is never pending.
- Writes (commit at the rising edge):
  - wrN with wrN_en=1 and wrN_addr!=0 writes wrN_data.
  - If wr0 and wr1 target the same non-zero address in the same cycle, wr1 wins.
- Reads (combinational, zero latency), priority per port k:
  1. addr==0 returns 0.
  2. wr1_en && wr1_addr==addr returns wr1_data.
  3. wr0_en && wr0_addr==addr returns wr0_data.
  4. Otherwise returns the stored value.
- Scoreboard, next state per index i!=0:
  - Set when sb_set_en && sb_set_addr==i.
  - Otherwise clear when a write (either port) targets i.
  - Otherwise hold.
  - Set wins over a same-cycle clear: the younger instruction's reservation survives the older write-back.
  - sb_set_addr==0 is ignored.
  - Setting an already-pending bit leaves it at 1; there is no counting.
- rd_busy[k] = pending[addr_k] && no write to addr_k this cycle && addr_k!=0.
  - A write-back in the same cycle un-busies the read and forwards its data.
  - A same-cycle sb_set does not affect rd_busy until the next cycle.
- Outputs have no internal pipeline. rd_data and rd_busy are combinational from inputs and state; pending is a direct flop output.
- Addresses are always in range: DEPTH is a power of two, so there is no out-of-range case.

Decomposition:
- Shared package cpu_rf_pkg holds:
  - constants REG_ZERO=0, REG_SP=29, SP_RESET=32'h000007fc;
  - typedef rf_addr_t (ADDR_W bits);
  - typedef rf_data_t (DATA_W bits).
- One natural sub-module: regfile_read_port, one instance per read port via generate. It performs the zero check, the two-level forwarding mux and the busy computation.
- Storage, write logic and scoreboard stay in regfile_mp.

Test Plan:
- Reset check: pulse reset_n low mid-cycle, then read r29 and r5 -> rd_data = 32'h000007fc and 0; pending = 0; the async clear happens without waiting for a clock edge.
- Zero register: wr0 to r0 with 32'hDEADBEEF, then read r0 on both ports -> 0; pending[0] stays 0 after sb_set_addr=0.
- Write collision and forwarding: wr0(r7, 32'h11111111) and wr1(r7, 32'h22222222) in the same cycle; read r7 that cycle -> 32'h22222222; next cycle stored r7 = 32'h22222222.
- Load-use stall: sb_set r3, then read r3 next cycle -> rd_busy=1; then wr1(r3, 32'h0000ABCD) -> same-cycle rd_busy=0 with rd_data=32'h0000ABCD, and pending[3]=0 after the edge.
- Set/clear race: pending[4]=1, then in one cycle wr0(r4, 5) with sb_set r4 -> after the edge pending[4]=1 and r4=5; next-cycle read of r4 -> rd_busy=1.
- Parametrisation: NUM_RD=4, ADDR_W=3, SP_IDX=0 -> four independent reads return distinct written values; r7 resets to 0; pending is 8 bits wide.
